// File: rtl/multicycle_sequencer_pkg.sv
// Shared sequencer state encodings and state-width constant.
package multicycle_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_e;

endpackage

// File: rtl/multicycle_sequencer_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, sync reset to 0.
// One-cycle latency from inc to count; never wraps.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with HALT; 4 cycles per instruction minimum.
// Stalls in FETCH until mem_ack and in EXECUTE until exec_done.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                OP_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    instr,
  input  logic               mem_ack,
  input  logic               exec_done,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt_req,
  input  logic               run,
  output logic               mem_req,
  output logic               decode_en,
  output logic               exec_en,
  output logic               wb_en,
  output logic               halted,
  output logic               retired,
  output logic [ADDR_W-1:0]  pc,
  output logic [OP_W-1:0]    ir,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   instr_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OP_W-1:0]   ir_q, ir_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          ir_d    = instr;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        // Halt wins over a simultaneous branch and leaves pc pointing past the halt.
        if (exec_done) begin
          if (halt_req) begin
            state_d = ST_HALT;
          end else begin
            if (branch_taken) begin
              pc_d = branch_target;
            end
            state_d = ST_WRITEBACK;
          end
        end
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALT: begin
        if (run) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign mem_req   = (state_q == ST_FETCH);
  assign decode_en = (state_q == ST_DECODE);
  assign exec_en   = (state_q == ST_EXECUTE);
  assign wb_en     = (state_q == ST_WRITEBACK);
  assign retired   = (state_q == ST_WRITEBACK);
  assign halted    = (state_q == ST_HALT);
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign state     = state_q;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (retired),
    .count (instr_count)
  );

endmodule
